mdu_scheduler: RTL and testbench

//  Sequences the E-stage multiply/divide unit for the decoder's MDUOp/MDU_start/MDU_related outputs.

---
 rtl/mdu_scheduler_pkg.sv | 28 ++
 rtl/mdu_scheduler_if.sv | 28 ++
 rtl/mdu_scheduler_arith.sv | 64 ++++++
 rtl/mdu_scheduler.sv | 105 ++++++++++
 tb/tb_mdu_scheduler.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_scheduler_pkg.sv
// mdu_scheduler_pkg: shared MDU opcode encodings, default latencies and
// small opcode-class helpers used by the scheduler and its arithmetic core.
package mdu_scheduler_pkg;

    // Decoder MDUOp encoding (E stage)
    typedef enum logic [2:0] {
        MDU_NOP   = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_op_e;

    // Busy cycles following the start edge
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic is_mult(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

    function automatic logic is_div(input mdu_op_e op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_scheduler_if.sv
// mdu_scheduler_if: E-stage MDU control/operand bundle plus the busy/stall
// and HI/LO results returned to the pipeline.
//   master: decoder/pipeline side (drives start, op, operands, exc_block, mdu_rel_d)
//   slave : mdu_scheduler side (drives busy, stall_req, hi, lo)
interface mdu_scheduler_if;
    import mdu_scheduler_pkg::*;

    logic        start;
    mdu_op_e     mdu_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        exc_block;
    logic        mdu_rel_d;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, mdu_op, rs_val, rt_val, exc_block, mdu_rel_d,
        input  busy, stall_req, hi, lo
    );

    modport slave (
        input  start, mdu_op, rs_val, rt_val, exc_block, mdu_rel_d,
        output busy, stall_req, hi, lo
    );
endinterface

// File: rtl/mdu_scheduler_arith.sv
// mdu_arith: combinational 32x32 multiply/divide core.
//   op        in   latched MDU op
//   a, b      in   latched rs / rt operands
//   hi_n/lo_n out  next HI/LO value for the op
//   hold      out  1 = leave HI/LO untouched (divide by zero or non-arith op)
// Signed divide works on magnitudes and re-applies signs, so the
// 0x80000000 / -1 corner falls out naturally as 0x80000000 rem 0.
module mdu_arith
    import mdu_scheduler_pkg::*;
(
    input  mdu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_n,
    output logic [31:0] lo_n,
    output logic        hold
);
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] a_mag, b_mag, b_safe, bs_safe;
    logic        [31:0] qs_mag, rs_mag, qu, ru;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'b0, a} * {32'b0, b};

    assign a_mag = a[31] ? (32'd0 - a) : a;
    assign b_mag = b[31] ? (32'd0 - b) : b;

    // Divisor forced non-zero so the result is defined; hold masks it anyway
    assign b_safe  = (b == 32'd0) ? 32'd1 : b;
    assign bs_safe = (b == 32'd0) ? 32'd1 : b_mag;

    assign qs_mag = a_mag / bs_safe;
    assign rs_mag = a_mag % bs_safe;
    assign qu     = a / b_safe;
    assign ru     = a % b_safe;

    always_comb begin
        hi_n = '0;
        lo_n = '0;
        hold = 1'b1;
        case (op)
            MDU_MULT: begin
                {hi_n, lo_n} = prod_s;
                hold         = 1'b0;
            end
            MDU_MULTU: begin
                {hi_n, lo_n} = prod_u;
                hold         = 1'b0;
            end
            MDU_DIV: begin
                lo_n = (a[31] ^ b[31]) ? (32'd0 - qs_mag) : qs_mag;
                hi_n = a[31] ? (32'd0 - rs_mag) : rs_mag;
                hold = (b == 32'd0);
            end
            MDU_DIVU: begin
                lo_n = qu;
                hi_n = ru;
                hold = (b == 32'd0);
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mdu_scheduler.sv
// mdu_scheduler: E-stage multiply/divide sequencer.
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-high reset, clears all state
//   bus    slave modport of mdu_scheduler_if:
//          start/mdu_op/rs_val/rt_val/exc_block/mdu_rel_d in,
//          busy (registered), stall_req (combinational), hi, lo out
// Operands are latched on the start edge; a down-counter holds busy for
// exactly MULT_CYCLES/DIV_CYCLES cycles, then HI/LO take the result on the
// edge where busy drops. MTHI/MTLO write directly when not busy.
module mdu_scheduler
    import mdu_scheduler_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input logic            clk,
    input logic            reset,
    mdu_scheduler_if.slave bus
);
    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic               busy_q;
    logic [31:0]        hi_q, lo_q;
    logic [31:0]        rs_q, rt_q;
    mdu_op_e            op_q;

    logic               start_eff, wr_eff;
    logic [31:0]        hi_n, lo_n;
    logic               hold;

    assign start_eff = bus.start & ~bus.exc_block & (state == IDLE);
    assign wr_eff    = ~bus.exc_block & ~busy_q &
                       ((bus.mdu_op == MDU_MTHI) | (bus.mdu_op == MDU_MTLO));

    mdu_arith u_arith (
        .op   (op_q),
        .a    (rs_q),
        .b    (rt_q),
        .hi_n (hi_n),
        .lo_n (lo_n),
        .hold (hold)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            rs_q   <= '0;
            rt_q   <= '0;
            op_q   <= MDU_NOP;
        end else begin
            // wr_eff requires ~busy, so it never collides with the RUN writeback
            if (wr_eff) begin
                if (bus.mdu_op == MDU_MTHI) hi_q <= bus.rs_val;
                else                        lo_q <= bus.rs_val;
            end
            case (state)
                IDLE: begin
                    if (start_eff) begin
                        op_q   <= bus.mdu_op;
                        rs_q   <= bus.rs_val;
                        rt_q   <= bus.rt_val;
                        cnt    <= is_mult(bus.mdu_op) ? CNT_W'(MULT_CYCLES - 1)
                                                      : CNT_W'(DIV_CYCLES - 1);
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (cnt == '0) begin
                        if (!hold) begin
                            hi_q <= hi_n;
                            lo_q <= lo_n;
                        end
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A start while busy is a hazard-unit bug; it is ignored by the FSM above
    always @(posedge clk) begin
        assert (reset || !(bus.start && busy_q))
            else $warning("mdu_scheduler: start while busy ignored");
    end

    assign bus.busy      = busy_q;
    assign bus.stall_req = bus.mdu_rel_d & (busy_q | start_eff);
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

endmodule

// File: tb/tb_mdu_scheduler.sv
// tb_mdu_scheduler: scoreboard bench. The driver pushes the reference
// HI/LO and busy length for each MULT/DIV; a negedge monitor pops and
// compares whenever busy falls. Direct checks cover reset, stall and writes.
module tb_mdu_scheduler;
    import mdu_scheduler_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mdu_scheduler_if bus ();

    mdu_scheduler #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          passes = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    // Architectural reference: HI/LO after an op, from plain 64-bit arithmetic
    function automatic void model_op(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b);
        longint      q, r;
        logic [63:0] p;
        case (op)
            MDU_MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            MDU_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            MDU_DIV: if (b != 0) begin
                q = longint'($signed(a)) / longint'($signed(b));
                r = longint'($signed(a)) % longint'($signed(b));
                m_lo = q[31:0]; m_hi = r[31:0];
            end
            MDU_DIVU: if (b != 0) begin
                m_lo = a / b; m_hi = a % b;
            end
            default: ;
        endcase
    endfunction

    // Monitor: result is compared in the first cycle busy reads 0
    initial begin
        logic busy_prev;
        int   run_len;
        exp_t e;
        busy_prev = 1'b0;
        run_len   = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_prev = 1'b0;
                run_len   = 0;
            end else begin
                if (bus.busy) run_len++;
                if (!bus.busy && busy_prev) begin
                    if (sb.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_result: hi=%h lo=%h with empty scoreboard", bus.hi, bus.lo);
                    end else begin
                        e = sb.pop_front();
                        check("sb_hi", 64'(bus.hi), 64'(e.hi));
                        check("sb_lo", 64'(bus.lo), 64'(e.lo));
                        check("sb_busy_len", 64'(run_len), 64'(e.cycles));
                    end
                    run_len = 0;
                end
                busy_prev = bus.busy;
            end
        end
    end

    task automatic run_op(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic rel, input logic mtlo_mid, input logic b2b);
        int n, k;
        n = is_mult(op) ? MC : DC;
        if (!b2b) begin
            @(posedge clk); #1;
        end
        bus.start = 1'b1; bus.mdu_op = op; bus.rs_val = a; bus.rt_val = b;
        bus.exc_block = 1'b0; bus.mdu_rel_d = rel;
        #1 check("stall_start", 64'(bus.stall_req), 64'(rel));
        model_op(op, a, b);
        sb.push_back('{m_hi, m_lo, n});
        @(posedge clk); #1;
        bus.start = 1'b0; bus.mdu_op = MDU_NOP;
        k = 0;
        while (bus.busy && k < 60) begin
            if (mtlo_mid && k == 2) begin
                bus.mdu_op = MDU_MTLO; bus.rs_val = 32'hDEADBEEF;
            end else begin
                bus.mdu_op = MDU_NOP;
            end
            check("stall_busy", 64'(bus.stall_req), 64'(rel));
            @(posedge clk); #1;
            k++;
        end
        check("busy_edges", 64'(k), 64'(n));
        check("stall_after", 64'(bus.stall_req), 64'(0));
        bus.mdu_rel_d = 1'b0;
    endtask

    task automatic do_wr(input mdu_op_e op, input logic [31:0] v, input logic exc);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.mdu_op = op; bus.rs_val = v; bus.exc_block = exc;
        @(posedge clk); #1;
        bus.mdu_op = MDU_NOP; bus.exc_block = 1'b0;
        if (!exc) begin
            if (op == MDU_MTHI) m_hi = v; else m_lo = v;
        end
        check("wr_hi", 64'(bus.hi), 64'(m_hi));
        check("wr_lo", 64'(bus.lo), 64'(m_lo));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        mdu_op_e op;
        logic    b2b;
        bus.start = 1'b0; bus.mdu_op = MDU_NOP; bus.rs_val = '0; bus.rt_val = '0;
        bus.exc_block = 1'b0; bus.mdu_rel_d = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_hi", 64'(bus.hi), 64'(0));
        check("rst_lo", 64'(bus.lo), 64'(0));
        check("rst_stall", 64'(bus.stall_req), 64'(0));

        // Reset mid-RUN aborts a MULT 3*4 and clears a preloaded HI
        do_wr(MDU_MTHI, 32'h55, 1'b0);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.mdu_op = MDU_MULT; bus.rs_val = 32'd3; bus.rt_val = 32'd4;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.mdu_op = MDU_NOP;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("midrst_busy", 64'(bus.busy), 64'(0));
        check("midrst_hi", 64'(bus.hi), 64'(0));
        check("midrst_lo", 64'(bus.lo), 64'(0));
        m_hi = '0; m_lo = '0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("postrst_busy", 64'(bus.busy), 64'(0));
        check("postrst_hi", 64'(bus.hi), 64'(0));
        check("postrst_lo", 64'(bus.lo), 64'(0));

        // MULT / MULTU
        run_op(MDU_MULT, 32'hFFFFFFFF, 32'd2, 1'b1, 1'b0, 1'b0);
        check("mult_hi", 64'(bus.hi), 64'h0FFFFFFFF);
        check("mult_lo", 64'(bus.lo), 64'h0FFFFFFFE);
        run_op(MDU_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0, 1'b0);
        check("multu_hi", 64'(bus.hi), 64'h1);
        check("multu_lo", 64'(bus.lo), 64'h0FFFFFFFE);

        // DIV, including the overflow corner
        run_op(MDU_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, 1'b0);
        check("div_lo", 64'(bus.lo), 64'h0FFFFFFFD);
        check("div_hi", 64'(bus.hi), 64'h0FFFFFFFF);
        run_op(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
        check("divovf_lo", 64'(bus.lo), 64'h080000000);
        check("divovf_hi", 64'(bus.hi), 64'h0);

        // Divide by zero leaves preloaded HI/LO untouched
        do_wr(MDU_MTHI, 32'h11, 1'b0);
        do_wr(MDU_MTLO, 32'h22, 1'b0);
        run_op(MDU_DIVU, 32'h1234, 32'h0, 1'b1, 1'b0, 1'b0);
        check("divz_hi", 64'(bus.hi), 64'h11);
        check("divz_lo", 64'(bus.lo), 64'h22);
        run_op(MDU_DIV, 32'h80000000, 32'h0, 1'b0, 1'b0, 1'b0);

        // exc_block drops start and writes, not an in-flight op
        @(posedge clk); #1;
        bus.start = 1'b1; bus.mdu_op = MDU_MULT; bus.rs_val = 32'd9; bus.rt_val = 32'd9;
        bus.exc_block = 1'b1; bus.mdu_rel_d = 1'b1;
        #1 check("exc_stall", 64'(bus.stall_req), 64'(0));
        @(posedge clk); #1;
        bus.start = 1'b0; bus.mdu_op = MDU_NOP; bus.exc_block = 1'b0; bus.mdu_rel_d = 1'b0;
        check("exc_busy", 64'(bus.busy), 64'(0));
        repeat (3) @(posedge clk);
        #1 check("exc_busy_later", 64'(bus.busy), 64'(0));
        do_wr(MDU_MTHI, 32'd5, 1'b1);
        run_op(MDU_MULT, 32'd7, 32'd6, 1'b0, 1'b1, 1'b0);
        check("mtlo_busy_lo", 64'(bus.lo), 64'd42);

        // Randomized mix, with back-to-back starts
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 5))
                0: op = MDU_MULT;
                1: op = MDU_MULTU;
                2: op = MDU_DIV;
                3: op = MDU_DIVU;
                4: op = MDU_MTHI;
                default: op = MDU_MTLO;
            endcase
            b2b = 1'($urandom_range(0, 1));
            if (op == MDU_MTHI || op == MDU_MTLO)
                do_wr(op, $urandom, 1'($urandom_range(0, 3) == 0));
            else
                run_op(op, pick(), pick(), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 3) == 0), b2b);
        end

        repeat (3) @(posedge clk);
        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Hard bound on run time
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
